// File: rtl/fp_normalize_round_pkg.sv
// Shared widths, constants and FSM encoding for the single-precision
// normalise/round stage.
package fp_normalize_round_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_MANT_W = FP_FRAC_W + 4;
    localparam int BIAS      = 127;
    localparam int EXP_MAX   = 255;

    // Raw mantissa layout: {carry, hidden, fraction, guard, sticky}
    localparam int MANT_CARRY   = FP_MANT_W - 1;
    localparam int MANT_HIDDEN  = FP_MANT_W - 2;
    localparam int MANT_FRAC_LO = 2;
    localparam int MANT_GUARD   = 1;
    localparam int MANT_STICKY  = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/fp_normalize_round_rne.sv
// Combinational round-to-nearest-even of a normalised significand, with
// exponent bump on mantissa carry and saturation to infinity.
module fp_round_rne
    import fp_normalize_round_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W
) (
    input  logic [FRAC_W+2:0]       sig_i,
    input  logic signed [EXP_W+1:0] exp_i,
    output logic [FRAC_W-1:0]       frac_o,
    output logic [EXP_W-1:0]        exp_o,
    output logic                    overflow_o,
    output logic                    inexact_o
);

    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] EXP_ONE = 1;
    localparam logic signed [XW-1:0] EXP_SAT = XW'((1 << EXP_W) - 1);

    logic                 lsb;
    logic                 guard;
    logic                 sticky;
    logic                 inc;
    logic                 carry;
    logic [FRAC_W-1:0]    frac_inc;
    logic signed [XW-1:0] exp_r;

    always_comb begin
        lsb      = sig_i[MANT_FRAC_LO];
        guard    = sig_i[MANT_GUARD];
        sticky   = sig_i[MANT_STICKY];
        inc      = guard & (sticky | lsb);
        // Fraction wraps to zero exactly when {hidden, frac} is all ones.
        frac_inc = sig_i[FRAC_W+1:MANT_FRAC_LO] + FRAC_W'(inc);
        carry    = inc & (&sig_i[FRAC_W+2:MANT_FRAC_LO]);
        exp_r    = exp_i + (carry ? EXP_ONE : '0);

        overflow_o = (exp_r >= EXP_SAT);
        inexact_o  = guard | sticky;
        frac_o     = overflow_o ? '0 : frac_inc;
        exp_o      = overflow_o ? '1 : exp_r[EXP_W-1:0];
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-add normalise (one bit per cycle), RNE round and pack for IEEE-754
// single precision, with valid/ready on both sides and one item in flight.
module fp_normalize_round
    import fp_normalize_round_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+3:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_overflow,
    output logic                    out_underflow,
    output logic                    out_inexact
);

    localparam int MANT_W = FRAC_W + 4;
    localparam int XW     = EXP_W + 2;
    localparam int RW     = EXP_W + FRAC_W + 1;
    localparam int CARRY  = MANT_W - 1;
    localparam int HIDDEN = MANT_W - 2;
    localparam logic signed [XW-1:0] EXP_ONE = 1;
    localparam logic signed [XW-1:0] EXP_SAT = XW'((1 << EXP_W) - 1);

    state_e               state_q, state_d;
    logic                 sign_q, sign_d;
    logic signed [XW-1:0] exp_q, exp_d;
    logic [MANT_W-1:0]    mant_q, mant_d;
    logic [RW-1:0]        result_q, result_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 inx_q, inx_d;

    logic [FRAC_W-1:0]    rnd_frac;
    logic [EXP_W-1:0]     rnd_exp;
    logic                 rnd_ovf;
    logic                 rnd_inx;

    fp_round_rne #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round (
        .sig_i      (mant_q[HIDDEN:0]),
        .exp_i      (exp_q),
        .frac_o     (rnd_frac),
        .exp_o      (rnd_exp),
        .overflow_o (rnd_ovf),
        .inexact_o  (rnd_inx)
    );

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {2'b00, in_exp};
                    mant_d  = in_mant;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    inx_d   = 1'b0;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // Left shifts only lower the exponent, so this only fires on the captured value.
                if (exp_q == EXP_SAT) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, mant_q[HIDDEN-1:MANT_FRAC_LO]};
                    state_d  = S_OUT;
                end else if (mant_q == '0) begin
                    result_d = '0;
                    state_d  = S_OUT;
                end else if (mant_q[CARRY]) begin
                    mant_d  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = S_ROUND;
                end else if (!mant_q[HIDDEN] && (exp_q > EXP_ONE)) begin
                    mant_d = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                end else if (!mant_q[HIDDEN]) begin
                    result_d = {sign_q, {(RW-1){1'b0}}};
                    unf_d    = 1'b1;
                    state_d  = S_OUT;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                result_d = {sign_q, rnd_exp, rnd_frac};
                ovf_d    = rnd_ovf;
                inx_d    = rnd_inx;
                state_d  = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_OUT);
    assign out_result    = result_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_inexact   = inx_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed vector table, randomized vectors
// against an arithmetic reference model, backpressure and mid-flight reset.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_normalize_round #(
        .EXP_W  (8),
        .FRAC_W (23)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    typedef struct {
        logic        sign;
        logic [7:0]  e;
        logic [26:0] m;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
    } want_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Value-level reference: leading-one search, closed-form shift count, RNE on integers.
    function automatic want_t model(input logic s, input logic [7:0] e, input logic [26:0] m);
        want_t       r;
        int          ee, n, allowed, msb;
        logic [26:0] mm;
        logic [24:0] q;
        logic        g, st, inc;
        r.res = '0; r.ovf = 1'b0; r.unf = 1'b0; r.inx = 1'b0; r.lat = 1;
        if (e == 8'hFF) begin
            r.res = {s, 8'hFF, m[24:2]};
            return r;
        end
        if (m == '0) return r;
        ee = int'(e);
        mm = m;
        if (m[26]) begin
            mm = (m >> 1) | (m & 27'd1);
            ee = ee + 1;
            r.lat = 2;
        end else begin
            msb = 0;
            for (int b = 0; b < 26; b++) if (m[b]) msb = b;
            n = 25 - msb;
            allowed = (ee > 1) ? ee - 1 : 0;
            if (n > allowed) begin
                r.res = {s, 31'b0};
                r.unf = 1'b1;
                r.lat = allowed + 1;
                return r;
            end
            mm = m << n;
            ee = ee - n;
            r.lat = n + 2;
        end
        g     = mm[1];
        st    = mm[0];
        inc   = g & (st | mm[2]);
        r.inx = g | st;
        q = {1'b0, mm[25:2]} + 25'(inc);
        if (q[24]) begin
            ee = ee + 1;
            q  = q >> 1;
        end
        if (ee >= 255) begin
            r.res = {s, 8'hFF, 23'b0};
            r.ovf = 1'b1;
        end else begin
            r.res = {s, 8'(ee), q[22:0]};
        end
        return r;
    endfunction

    task automatic run_one(input string tag, input logic s, input logic [7:0] e,
                           input logic [26:0] m, input want_t want);
        int lat;
        bit got;
        @(negedge clk);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (out_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        check({tag, " valid"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, " result"}, out_result, want.res);
            check({tag, " overflow"}, 32'(out_overflow), 32'(want.ovf));
            check({tag, " underflow"}, 32'(out_underflow), 32'(want.unf));
            check({tag, " inexact"}, 32'(out_inexact), 32'(want.inx));
            check({tag, " latency"}, 32'(lat), 32'(want.lat));
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, " drained"}, 32'({out_valid, in_ready}), 32'b01);
        end else begin
            @(negedge clk); rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    vec_t  vecs[12];
    want_t w;
    int    vcount;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;

        vecs[0]  = '{1'b0, 8'd127, 27'h2000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 2};
        vecs[1]  = '{1'b0, 8'd127, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 2};
        vecs[2]  = '{1'b0, 8'd127, 27'h0000004, 32'h34000000, 1'b0, 1'b0, 1'b0, 25};
        vecs[3]  = '{1'b0, 8'd127, 27'h2000006, 32'h3F800002, 1'b0, 1'b0, 1'b1, 2};
        vecs[4]  = '{1'b0, 8'd127, 27'h2000002, 32'h3F800000, 1'b0, 1'b0, 1'b1, 2};
        vecs[5]  = '{1'b0, 8'd254, 27'h7FFFFFF, 32'h7F800000, 1'b1, 1'b0, 1'b1, 2};
        vecs[6]  = '{1'b0, 8'd1,   27'h0800000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};
        vecs[7]  = '{1'b1, 8'd255, 27'h1234567, 32'hFFC8D159, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b1, 8'd100, 27'h0000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{1'b1, 8'd3,   27'h0000004, 32'h80000000, 1'b0, 1'b1, 1'b0, 3};
        vecs[10] = '{1'b0, 8'd10,  27'h1000001, 32'h04800000, 1'b0, 1'b0, 1'b1, 3};
        vecs[11] = '{1'b0, 8'd254, 27'h3FFFFFF, 32'h7F800000, 1'b1, 1'b0, 1'b1, 2};

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_result", out_result, 32'h0);
        check("reset flags", 32'({out_overflow, out_underflow, out_inexact}), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            w.res = vecs[i].res; w.ovf = vecs[i].ovf; w.unf = vecs[i].unf;
            w.inx = vecs[i].inx; w.lat = vecs[i].lat;
            run_one($sformatf("vec%0d", i), vecs[i].sign, vecs[i].e, vecs[i].m, w);
        end

        vcount = 250;
        for (int i = 0; i < vcount; i++) begin
            logic        s;
            logic [7:0]  e;
            logic [26:0] m;
            s = 1'($urandom);
            e = 8'($urandom_range(0, 255));
            if (i % 8 == 0) e = 8'($urandom_range(0, 4));
            if (i % 8 == 1) e = 8'($urandom_range(250, 255));
            m = 27'($urandom) >> $urandom_range(0, 26);
            run_one($sformatf("rand%0d", i), s, e, m, model(s, e, m));
        end

        // Backpressure: result frozen, input blocked, extra in_valid ignored.
        begin
            int lat;
            lat = 0;
            @(negedge clk);
            in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 27'h2000000;
            @(posedge clk); #1;
            in_valid = 1'b0;
            while (!out_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check("bp valid", 32'(out_valid), 32'd1);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'd127; in_mant = 27'h4000000;
                @(posedge clk); #1;
                check($sformatf("bp hold%0d result", c), out_result, 32'h3F800000);
                check($sformatf("bp hold%0d valid/ready", c), 32'({out_valid, in_ready}), 32'b10);
            end
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("bp drained", 32'({out_valid, in_ready}), 32'b01);
            lat = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (out_valid) lat++;
            end
            check("bp second input ignored", 32'(lat), 32'd0);
        end

        // Reset while normalising drops the transaction.
        begin
            int seen;
            @(negedge clk);
            in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 27'h0000004;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("midrst busy", 32'({out_valid, in_ready}), 32'b00);
            @(negedge clk); rst = 1'b1;
            @(posedge clk); #1;
            check("midrst idle", 32'({out_valid, in_ready}), 32'b01);
            @(negedge clk); rst = 1'b0;
            seen = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("midrst no output", 32'(seen), 32'd0);
            w.res = 32'h3F800000; w.ovf = 1'b0; w.unf = 1'b0; w.inx = 1'b0; w.lat = 2;
            run_one("after-rst", 1'b0, 8'd127, 27'h2000000, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
